// File: rtl/ex_result_stage.sv
// Execute-path result stage: signed-overflow detection, ADD/SUB saturation,
// Z/V/N flag register and a 2-entry skid buffer toward writeback.
module ex_result_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [15:0] in_sum,
    input  logic        in_a_msb,
    input  logic        in_b_msb,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_result,
    output logic        flag_z,
    output logic        flag_v,
    output logic        flag_n
);
    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_LOGIC = 2'b10;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] main_result_reg, main_result_next;
    logic [1:0]  main_op_reg, main_op_next;
    logic        main_ovf_reg, main_ovf_next;
    logic [15:0] skid_result_reg, skid_result_next;
    logic [1:0]  skid_op_reg, skid_op_next;
    logic        skid_ovf_reg, skid_ovf_next;
    logic        in_ready_reg, in_ready_next;
    logic        out_valid_reg, out_valid_next;
    logic        z_reg, z_next, v_reg, v_next, n_reg, n_next;

    logic        arith;
    logic        ovf;
    logic [15:0] sat_result;
    logic        accept;
    logic        deq;

    // Incoming entry, formed before it is buffered
    always_comb begin
        arith      = (in_op == OP_ADD) || (in_op == OP_SUB);
        ovf        = arith && (in_a_msb == in_b_msb) && (in_sum[15] != in_a_msb);
        sat_result = in_sum;
        if (ovf) begin
            sat_result = in_a_msb ? 16'h8000 : 16'h7FFF;
        end
    end

    // Flush masks both sides so neither a load nor a flag update happens
    assign accept = in_valid && in_ready_reg && !flush;
    assign deq    = out_valid_reg && out_ready && !flush;

    always_comb begin
        state_next       = state_reg;
        main_result_next = main_result_reg;
        main_op_next     = main_op_reg;
        main_ovf_next    = main_ovf_reg;
        skid_result_next = skid_result_reg;
        skid_op_next     = skid_op_reg;
        skid_ovf_next    = skid_ovf_reg;
        z_next           = z_reg;
        v_next           = v_reg;
        n_next           = n_reg;

        case (state_reg)
            S_EMPTY: begin
                if (accept) begin
                    state_next       = S_ONE;
                    main_result_next = sat_result;
                    main_op_next     = in_op;
                    main_ovf_next    = ovf;
                end
            end
            S_ONE: begin
                if (accept && deq) begin
                    main_result_next = sat_result;
                    main_op_next     = in_op;
                    main_ovf_next    = ovf;
                end else if (accept) begin
                    state_next       = S_TWO;
                    skid_result_next = sat_result;
                    skid_op_next     = in_op;
                    skid_ovf_next    = ovf;
                end else if (deq) begin
                    state_next = S_EMPTY;
                end
            end
            S_TWO: begin
                if (deq) begin
                    state_next       = S_ONE;
                    main_result_next = skid_result_reg;
                    main_op_next     = skid_op_reg;
                    main_ovf_next    = skid_ovf_reg;
                end
            end
            default: state_next = S_EMPTY;
        endcase

        if (deq) begin
            if ((main_op_reg == OP_ADD) || (main_op_reg == OP_SUB)) begin
                z_next = (main_result_reg == 16'h0000);
                n_next = main_result_reg[15];
                v_next = main_ovf_reg;
            end else if (main_op_reg == OP_LOGIC) begin
                z_next = (main_result_reg == 16'h0000);
            end
        end

        if (flush) begin
            state_next = S_EMPTY;
        end

        in_ready_next  = (state_next != S_TWO);
        out_valid_next = (state_next != S_EMPTY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= S_EMPTY;
            main_result_reg <= 16'h0000;
            main_op_reg     <= 2'b00;
            main_ovf_reg    <= 1'b0;
            skid_result_reg <= 16'h0000;
            skid_op_reg     <= 2'b00;
            skid_ovf_reg    <= 1'b0;
            in_ready_reg    <= 1'b1;
            out_valid_reg   <= 1'b0;
            z_reg           <= 1'b0;
            v_reg           <= 1'b0;
            n_reg           <= 1'b0;
        end else begin
            state_reg       <= state_next;
            main_result_reg <= main_result_next;
            main_op_reg     <= main_op_next;
            main_ovf_reg    <= main_ovf_next;
            skid_result_reg <= skid_result_next;
            skid_op_reg     <= skid_op_next;
            skid_ovf_reg    <= skid_ovf_next;
            in_ready_reg    <= in_ready_next;
            out_valid_reg   <= out_valid_next;
            z_reg           <= z_next;
            v_reg           <= v_next;
            n_reg           <= n_next;
        end
    end

    assign in_ready   = in_ready_reg;
    assign out_valid  = out_valid_reg;
    assign out_result = main_result_reg;
    assign flag_z     = z_reg;
    assign flag_v     = v_reg;
    assign flag_n     = n_reg;
endmodule

// File: tb/tb_ex_result_stage.sv
// Directed bench for ex_result_stage: saturation, flag rules, backpressure,
// flush and asynchronous reset, with hand-computed expectations.
module tb_ex_result_stage;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [15:0] in_sum;
    logic        in_a_msb;
    logic        in_b_msb;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic        flag_z, flag_v, flag_n;

    int n_checks = 0;
    int n_fail   = 0;

    ex_result_stage dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_sum     (in_sum),
        .in_a_msb   (in_a_msb),
        .in_b_msb   (in_b_msb),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .flag_z     (flag_z),
        .flag_v     (flag_v),
        .flag_n     (flag_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-16s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_flags(input string tag, input logic [2:0] exp_zvn);
        check(tag, {13'd0, flag_z, flag_v, flag_n}, {13'd0, exp_zvn});
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [15:0] sum,
                         input logic a, input logic b);
        in_valid = v;
        in_op    = op;
        in_sum   = sum;
        in_a_msb = a;
        in_b_msb = b;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 2'b00, 16'h0000, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b0;

        // Idle after reset
        check("rst_valid", {15'd0, out_valid}, 16'd0);
        check("rst_ready", {15'd0, in_ready}, 16'd1);
        check("rst_result", out_result, 16'h0000);
        check_flags("rst_flags", 3'b000);
        repeat (5) step();
        check("idle_valid", {15'd0, out_valid}, 16'd0);
        check("idle_ready", {15'd0, in_ready}, 16'd1);
        check_flags("idle_flags", 3'b000);

        // Positive saturation
        out_ready = 1'b1;
        drive(1'b1, 2'b00, 16'h8000, 1'b0, 1'b0);
        step();
        drive(1'b0, 2'b00, 16'h0000, 1'b0, 1'b0);
        check("psat_valid", {15'd0, out_valid}, 16'd1);
        check("psat_result", out_result, 16'h7FFF);
        check_flags("psat_pre_flags", 3'b000);
        step();
        check_flags("psat_flags", 3'b010);
        check("psat_drain", {15'd0, out_valid}, 16'd0);

        // Negative saturation (SUB 0x8000 - 1)
        drive(1'b1, 2'b01, 16'h7FFF, 1'b1, 1'b1);
        step();
        drive(1'b0, 2'b00, 16'h0000, 1'b0, 1'b0);
        check("nsat_result", out_result, 16'h8000);
        step();
        check_flags("nsat_flags", 3'b011);

        // LOGIC updates Z only, PASS changes nothing
        drive(1'b1, 2'b10, 16'h0000, 1'b0, 1'b0);
        step();
        drive(1'b0, 2'b00, 16'h0000, 1'b0, 1'b0);
        check("logic_result", out_result, 16'h0000);
        step();
        check_flags("logic_flags", 3'b111);
        drive(1'b1, 2'b11, 16'h1234, 1'b0, 1'b0);
        step();
        drive(1'b0, 2'b00, 16'h0000, 1'b0, 1'b0);
        check("pass_result", out_result, 16'h1234);
        step();
        check_flags("pass_flags", 3'b111);

        // Backpressure: two accepted, third held off until space frees
        out_ready = 1'b0;
        drive(1'b1, 2'b00, 16'h0001, 1'b0, 1'b0);
        step();
        check("bp1_ready", {15'd0, in_ready}, 16'd1);
        check("bp1_result", out_result, 16'h0001);
        drive(1'b1, 2'b00, 16'h0002, 1'b0, 1'b0);
        step();
        check("bp2_ready", {15'd0, in_ready}, 16'd0);
        check("bp2_result", out_result, 16'h0001);
        drive(1'b1, 2'b00, 16'h0003, 1'b0, 1'b0);
        step();
        check("bp3_ready", {15'd0, in_ready}, 16'd0);
        check("bp3_hold", out_result, 16'h0001);
        check_flags("bp3_flags", 3'b111);
        out_ready = 1'b1;
        step();
        check("bp_out2", out_result, 16'h0002);
        check("bp_out2_valid", {15'd0, out_valid}, 16'd1);
        check_flags("bp_flags1", 3'b000);
        step();
        drive(1'b0, 2'b00, 16'h0000, 1'b0, 1'b0);
        check("bp_out3", out_result, 16'h0003);
        check("bp_out3_valid", {15'd0, out_valid}, 16'd1);
        step();
        check("bp_drain", {15'd0, out_valid}, 16'd0);
        check_flags("bp_flags", 3'b000);

        // Flush from TWO with out_ready high
        out_ready = 1'b0;
        drive(1'b1, 2'b00, 16'hFFFF, 1'b1, 1'b0);
        step();
        drive(1'b1, 2'b00, 16'h0000, 1'b0, 1'b0);
        step();
        check("fl_two", {15'd0, in_ready}, 16'd0);
        out_ready = 1'b1;
        flush = 1'b1;
        drive(1'b1, 2'b00, 16'h0005, 1'b0, 1'b0);
        step();
        flush = 1'b0;
        drive(1'b0, 2'b00, 16'h0000, 1'b0, 1'b0);
        check("fl_valid", {15'd0, out_valid}, 16'd0);
        check("fl_ready", {15'd0, in_ready}, 16'd1);
        check_flags("fl_flags", 3'b000);
        step();
        check("fl_discard", {15'd0, out_valid}, 16'd0);

        // Make flags nonzero, refill to TWO, then reset between edges
        drive(1'b1, 2'b00, 16'h8000, 1'b0, 1'b0);
        step();
        drive(1'b0, 2'b00, 16'h0000, 1'b0, 1'b0);
        step();
        check_flags("pre_rst_flags", 3'b010);
        out_ready = 1'b0;
        drive(1'b1, 2'b00, 16'h0011, 1'b0, 1'b0);
        step();
        drive(1'b1, 2'b00, 16'h0022, 1'b0, 1'b0);
        step();
        drive(1'b0, 2'b00, 16'h0000, 1'b0, 1'b0);
        check("pre_rst_two", {15'd0, in_ready}, 16'd0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", {15'd0, out_valid}, 16'd0);
        check("arst_ready", {15'd0, in_ready}, 16'd1);
        check("arst_result", out_result, 16'h0000);
        check_flags("arst_flags", 3'b000);
        step();
        rst = 1'b0;
        drive(1'b1, 2'b11, 16'hBEEF, 1'b0, 1'b0);
        step();
        drive(1'b0, 2'b00, 16'h0000, 1'b0, 1'b0);
        check("post_rst_valid", {15'd0, out_valid}, 16'd1);
        check("post_rst_result", out_result, 16'hBEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ex_result_stage.md
# ex_result_stage

Registered result/flag stage directly downstream of the 16-bit carry-lookahead adder in the execute path. It takes the raw adder sum plus operand sign bits and detects signed overflow. It saturates ADD/SUB results and maintains the Z/V/N flag register. It hands the final result to writeback over a valid/ready handshake, using a 2-entry skid buffer so the adder path never sees a combinational ready.

## Interface
- No parameters; datapath width fixed at 16 bits.
- clk  input  1  single clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  upstream presents a result this cycle.
- in_ready  output  1  stage can accept; driven from a register only.
- in_op  input  2  00 ADD, 01 SUB, 10 LOGIC, 11 PASS.
- in_sum  input  16  adder Sum output.
- in_a_msb  input  1  bit 15 of adder A input.
- in_b_msb  input  1  bit 15 of adder B input as fed to the adder (already inverted for SUB).
- flush  input  1  synchronous discard of all buffered entries.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts.
- out_result  output  16  saturated/passed result.
- flag_z, flag_v, flag_n  output  1 each  architectural flag register.

## Operation
- Overflow: ovf = (in_a_msb == in_b_msb) && (in_sum[15] != in_a_msb). It is evaluated only for ADD/SUB and is 0 otherwise.
- Saturation (ADD/SUB only): ovf with in_a_msb=0 gives 0x7FFF; ovf with in_a_msb=1 gives 0x8000. Otherwise the result is in_sum.
- LOGIC/PASS: the result is in_sum unmodified.
- Each buffered entry holds result[15:0], op[1:0] and ovf.
- Flag update happens on the output handshake (out_valid && out_ready), using the departing entry:
  - ADD/SUB: Z = (result == 0), N = result[15], V = ovf. Z and N are computed from the saturated result.
  - LOGIC: Z = (result == 0); V and N hold.
  - PASS: no flag change.
- Buffer states:
  - EMPTY: main invalid, skid invalid.
  - ONE: main valid.
  - TWO: main valid, skid valid.
- Transitions:
  - EMPTY + input accepted → ONE.
  - ONE + input, no output → TWO (input goes to skid).
  - ONE + output, no input → EMPTY.
  - ONE + input and output → ONE (main reloaded).
  - TWO + output → ONE (skid moves to main).
  - TWO never accepts input.
- Accept condition: in_valid && in_ready.
- Ordering is strictly FIFO. No entry is dropped or duplicated under any stall pattern.
- Flush: next state is EMPTY.
  - Flags are not modified, even if out_ready is high that cycle.
  - An input presented in the same cycle is discarded.
- Reset: state EMPTY, out_result 0x0000, out_valid 0, in_ready 1, flags Z=0 V=0 N=0.

## Timing
- Latency is 1 cycle. Input accepted at edge k makes out_valid high after edge k, with out_result valid in that same cycle.
- Throughput is 1 per cycle while out_ready is held high.
- out_valid, out_result and in_ready are all register outputs. There is no combinational path from out_ready to in_ready.
- in_ready is 0 exactly while in state TWO.
- Flags change at the edge that completes the output handshake. They are visible the cycle after out_result departs.
- out_result holds stable while out_valid && !out_ready.
- Asynchronous reset mid-stall immediately clears out_valid and the flags, independent of clk.
- On release, reset deasserts synchronously to clk, and the first accept is allowed at the next edge.

## Test plan
- Reset, then check idle: rst pulse → out_valid=0, in_ready=1, out_result=0x0000, ZVN=000. Hold idle for 5 cycles → no change.
- Positive saturation: ADD with in_sum=0x8000, a_msb=0, b_msb=0, out_ready=1 → out_result=0x7FFF one cycle later. After the handshake, Z=0, V=1, N=0.
- Negative saturation: SUB 0x8000−0x0001 (in_sum=0x7FFF, a_msb=1, b_msb=1) → out_result=0x8000, then Z=0, V=1, N=1.
- LOGIC flag rules: after the SUB case, LOGIC with in_sum=0x0000 → Z=1 with V=1, N=1 held. Then PASS 0x1234 → out_result=0x1234 and flags unchanged.
- Backpressure: out_ready=0, present ADDs of sums 0x0001, 0x0002, 0x0003 back-to-back.
  - First two are accepted; in_ready=0 from the cycle after the second accept.
  - Raise out_ready → outputs appear as 0x0001, 0x0002, 0x0003 in order with no gaps.
  - Final flags are Z=0, V=0, N=0.
- Flush and reset mid-operation:
  - In TWO with out_ready=1, assert flush → out_valid=0 next cycle and flags unchanged.
  - Refill to TWO, then assert rst asynchronously between edges → out_valid=0 and ZVN=000 immediately.
